// File: rtl/bist_pkg.sv
// Shared types and constants for the logic-BIST sequencer and its pattern generator.
// Also holds the MISR width so the MISR block and this controller agree on signature size.
package bist_pkg;

  localparam int MISR_W = 8;
  localparam logic [MISR_W-1:0] LFSR_TAPS     = 8'hB8;
  localparam logic [MISR_W-1:0] LFSR_SEED_DEF = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FLUSH,
    COMPARE,
    DONE
  } bist_state_e;

  typedef struct packed {
    logic mode;
    logic cut_rst;
    logic misr_rst;
    logic busy;
    logic done;
  } bist_flags_t;

  // Per-state output flags, registered alongside the state so outputs are glitch-free
  function automatic bist_flags_t flags_of(bist_state_e s);
    bist_flags_t f;
    f          = '0;
    f.mode     = (s == INIT) || (s == RUN) || (s == FLUSH);
    f.cut_rst  = (s == INIT);
    f.misr_rst = (s == INIT);
    f.busy     = (s == INIT) || (s == RUN) || (s == FLUSH) || (s == COMPARE);
    f.done     = (s == DONE);
    return f;
  endfunction

endpackage

// File: rtl/bist_if.sv
// Control/status bundle between the BIST sequencer (master) and the test host, CUT mux and MISR (slave).
interface bist_if import bist_pkg::*; #(parameter int NBIT = MISR_W);

  logic            bist_start;
  logic            bist_abort;
  logic [NBIT-1:0] signature;
  logic            bist_mode;
  logic [3:0]      req_tpg;
  logic            cut_rst;
  logic            misr_rst;
  logic            bist_busy;
  logic            bist_done;
  logic            bist_pass;
  logic [NBIT-1:0] sig_q;

  modport master (
    input  bist_start, bist_abort, signature,
    output bist_mode, req_tpg, cut_rst, misr_rst, bist_busy, bist_done, bist_pass, sig_q
  );

  modport slave (
    output bist_start, bist_abort, signature,
    input  bist_mode, req_tpg, cut_rst, misr_rst, bist_busy, bist_done, bist_pass, sig_q
  );

endinterface

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR pattern generator; load has priority over advance.
module bist_lfsr import bist_pkg::*; #(
  parameter int              NBIT = MISR_W,
  parameter logic [NBIT-1:0] TAPS = LFSR_TAPS
) (
  input  logic            clk,
  input  logic            load,
  input  logic            en,
  input  logic [NBIT-1:0] seed,
  output logic [NBIT-1:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= seed;
    end else if (en) begin
      q <= {q[NBIT-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/bist_ctrl.sv
// Logic-BIST sequencer for the 4-requester arbiter: drives LFSR patterns into the CUT,
// drains the pipeline, then latches and judges the MISR signature.
module bist_ctrl import bist_pkg::*; #(
  parameter int              NBIT      = MISR_W,
  parameter int              NPAT      = 255,
  parameter int              LAT       = 2,
  parameter logic [NBIT-1:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter logic [NBIT-1:0] GOLDEN    = '0
) (
  input logic   clk,
  input logic   rst,
  bist_if.master bus
);

  localparam int CW = $clog2(NPAT + 1);
  localparam int DW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST_PAT   = CW'(NPAT - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(LAT - 1);

  bist_state_e     state;
  bist_flags_t     flags;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   drain;
  logic            pass;
  logic [NBIT-1:0] sig;
  logic [NBIT-1:0] lfsr;
  logic            lfsr_load;
  logic            lfsr_en;

  assign lfsr_load = rst || (state == INIT);
  assign lfsr_en   = (state == RUN);

  bist_lfsr #(.NBIT(NBIT)) u_lfsr (
    .clk  (clk),
    .load (lfsr_load),
    .en   (lfsr_en),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  // Abort beats every transition, including a simultaneous start; sig_q survives it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flags <= flags_of(IDLE);
      cnt   <= '0;
      drain <= '0;
      pass  <= 1'b0;
      sig   <= '0;
    end else if (bus.bist_abort) begin
      state <= IDLE;
      flags <= flags_of(IDLE);
      pass  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.bist_start) begin
            state <= INIT;
            flags <= flags_of(INIT);
            pass  <= 1'b0;
          end
        end
        INIT: begin
          state <= RUN;
          flags <= flags_of(RUN);
          cnt   <= '0;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_PAT) begin
            state <= FLUSH;
            flags <= flags_of(FLUSH);
            drain <= '0;
          end
        end
        FLUSH: begin
          drain <= drain + 1'b1;
          if (drain == LAST_DRAIN) begin
            state <= COMPARE;
            flags <= flags_of(COMPARE);
          end
        end
        COMPARE: begin
          sig   <= bus.signature;
          pass  <= (bus.signature == GOLDEN);
          state <= DONE;
          flags <= flags_of(DONE);
        end
        default: begin
          state <= IDLE;
          flags <= flags_of(IDLE);
        end
      endcase
    end
  end

  // A zero LFSR would lock up and silently apply a constant pattern
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (lfsr != '0);
    end
  end

  assign bus.bist_mode = flags.mode;
  assign bus.cut_rst   = flags.cut_rst;
  assign bus.misr_rst  = flags.misr_rst;
  assign bus.bist_busy = flags.busy;
  assign bus.bist_done = flags.done;
  assign bus.bist_pass = pass;
  assign bus.sig_q     = sig;
  assign bus.req_tpg   = lfsr[3:0];

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl with a behavioural CUT (fixed-priority arbiter) and MISR.
// Expected signatures are queued at each start and popped when bist_done is observed.
module tb_bist_ctrl;

  localparam int         NBIT    = 8;
  localparam int         NPAT    = 8;
  localparam int         LAT     = 2;
  localparam logic [7:0] SEED    = 8'h01;
  localparam int         RUN_LEN = NPAT + LAT + 3;

  typedef enum int {P_IDLE, P_INIT, P_RUN, P_FLUSH, P_COMPARE, P_DONE} phase_e;

  typedef struct packed {
    logic [7:0] sig;
    logic       pass;
  } exp_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] arb(input logic [3:0] r);
    return r & (~r + 4'd1);
  endfunction

  function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [3:0] g);
    return lfsr_next(s) ^ {4'h0, g};
  endfunction

  // Signature seen in COMPARE: RUN feeds lfsr_k, FLUSH feeds the frozen lfsr_NPAT
  function automatic logic [7:0] model_sig(input int fault_k);
    logic [7:0] l;
    logic [7:0] s;
    logic [3:0] g;
    logic [3:0] g_n;
    l = SEED;
    s = 8'h00;
    g = 4'h0;
    for (int c = 0; c < NPAT + LAT; c++) begin
      g_n = arb(l[3:0]);
      if (c == fault_k) g_n = g_n ^ 4'b0001;
      s = misr_next(s, g);
      g = g_n;
      if (c < NPAT) l = lfsr_next(l);
    end
    return s;
  endfunction

  localparam logic [7:0] GOLDEN = model_sig(-1);

  logic clk = 1'b0;
  logic rst;
  logic inject = 1'b0;
  logic [3:0] grant = 4'h0;
  logic [7:0] misr  = 8'h00;
  logic [3:0] t1_req [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3};

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bist_if #(.NBIT(NBIT)) bus ();

  bist_ctrl #(
    .NBIT      (NBIT),
    .NPAT      (NPAT),
    .LAT       (LAT),
    .LFSR_SEED (SEED),
    .GOLDEN    (GOLDEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // CUT grant register and MISR; inject flips grant bit 0 to model a stuck fault
  always @(posedge clk) begin
    if (bus.cut_rst) grant <= 4'h0;
    else grant <= arb(bus.bist_mode ? bus.req_tpg : 4'h0) ^ {3'b000, inject};
    if (bus.misr_rst) misr <= 8'h00;
    else misr <= misr_next(misr, grant);
  end

  assign bus.signature = misr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic phase_e phase_at(input int cyc);
    if (cyc == 1) return P_INIT;
    if (cyc <= NPAT + 1) return P_RUN;
    if (cyc <= NPAT + LAT + 1) return P_FLUSH;
    if (cyc == NPAT + LAT + 2) return P_COMPARE;
    return P_DONE;
  endfunction

  // {mode, cut_rst, misr_rst, busy, done}
  function automatic logic [4:0] flags_exp(input phase_e p);
    logic [4:0] f;
    f    = 5'b0;
    f[4] = (p == P_INIT) || (p == P_RUN) || (p == P_FLUSH);
    f[3] = (p == P_INIT);
    f[2] = (p == P_INIT);
    f[1] = (p != P_IDLE) && (p != P_DONE);
    f[0] = (p == P_DONE);
    return f;
  endfunction

  function automatic logic [4:0] flags_obs();
    return {bus.bist_mode, bus.cut_rst, bus.misr_rst, bus.bist_busy, bus.bist_done};
  endfunction

  // One run from IDLE/DONE; optionally fault a RUN cycle or kill the run by abort or rst
  task automatic applyStimulus(input string tag, input int fault_k, input int kill_at, input bit kill_rst);
    exp_t       e;
    phase_e     p;
    logic [7:0] l;
    logic [7:0] sig_before;
    e.sig  = model_sig(fault_k);
    e.pass = (e.sig == GOLDEN);
    sb.push_back(e);
    sig_before     = bus.sig_q;
    l              = SEED;
    bus.bist_start = 1'b1;
    @(negedge clk);
    bus.bist_start = 1'b0;
    for (int cyc = 1; cyc <= RUN_LEN; cyc++) begin
      p = phase_at(cyc);
      checkOutput({tag, "_flags"}, 32'(flags_obs()), 32'(flags_exp(p)));
      if (cyc == 1) checkOutput({tag, "_pass_clr"}, 32'(bus.bist_pass), 32'(0));
      if (p == P_RUN) begin
        checkOutput({tag, "_req"}, 32'(bus.req_tpg), 32'(l[3:0]));
        if (cyc - 2 < 6) checkOutput({tag, "_t1req"}, 32'(bus.req_tpg), 32'(t1_req[cyc - 2]));
        l = lfsr_next(l);
      end
      if (p == P_DONE) begin
        e = sb.pop_front();
        checkOutput({tag, "_sig"}, 32'(bus.sig_q), 32'(e.sig));
        checkOutput({tag, "_pass"}, 32'(bus.bist_pass), 32'(e.pass));
      end
      inject = (fault_k >= 0) && (cyc == fault_k + 2);
      if (cyc == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else bus.bist_abort = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.bist_abort = 1'b0;
        inject         = 1'b0;
        void'(sb.pop_back());
        checkOutput({tag, "_kill_flags"}, 32'(flags_obs()), 32'(flags_exp(P_IDLE)));
        checkOutput({tag, "_kill_pass"}, 32'(bus.bist_pass), 32'(0));
        if (kill_rst) begin
          checkOutput({tag, "_kill_req"}, 32'(bus.req_tpg), 32'(SEED[3:0]));
          checkOutput({tag, "_kill_sigq"}, 32'(bus.sig_q), 32'(0));
        end else begin
          checkOutput({tag, "_kill_sigq"}, 32'(bus.sig_q), 32'(sig_before));
        end
        return;
      end
      if (cyc < RUN_LEN) @(negedge clk);
    end
    inject = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   rises;
    int   fall_cyc;
    logic prev_done;

    rst            = 1'b1;
    bus.bist_start = 1'b0;
    bus.bist_abort = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_flags", 32'(flags_obs()), 32'(flags_exp(P_IDLE)));
    checkOutput("rst_req", 32'(bus.req_tpg), 32'(SEED[3:0]));
    checkOutput("rst_sigq", 32'(bus.sig_q), 32'(0));
    checkOutput("rst_pass", 32'(bus.bist_pass), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    bus.bist_start = 1'b1;
    bus.bist_abort = 1'b1;
    @(negedge clk);
    bus.bist_start = 1'b0;
    bus.bist_abort = 1'b0;
    checkOutput("both_flags", 32'(flags_obs()), 32'(flags_exp(P_IDLE)));

    applyStimulus("good", -1, -1, 1'b0);
    applyStimulus("fault", 2, -1, 1'b0);
    checkOutput("fault_sig_ne", 32'(bus.sig_q != GOLDEN), 32'(1));
    applyStimulus("abort", -1, 3, 1'b0);
    applyStimulus("rerun", -1, -1, 1'b0);
    applyStimulus("rstflush", -1, NPAT + 2, 1'b1);

    // Back-to-back runs with start held high through DONE
    e.sig  = model_sig(-1);
    e.pass = 1'b1;
    sb.push_back(e);
    sb.push_back(e);
    rises          = 0;
    fall_cyc       = -1;
    prev_done      = 1'b0;
    bus.bist_start = 1'b1;
    for (int cyc = 1; cyc <= 3 * RUN_LEN && rises < 2; cyc++) begin
      @(negedge clk);
      if (bus.bist_done && !prev_done) begin
        rises++;
        e = sb.pop_front();
        checkOutput("b2b_sig", 32'(bus.sig_q), 32'(e.sig));
        checkOutput("b2b_pass", 32'(bus.bist_pass), 32'(e.pass));
        if (rises == 1) checkOutput("b2b_latency", 32'(cyc), 32'(RUN_LEN));
        else checkOutput("b2b_low_len", 32'(cyc - fall_cyc), 32'(1 + NPAT + LAT + 1));
      end
      if (!bus.bist_done && prev_done) fall_cyc = cyc;
      prev_done = bus.bist_done;
    end
    bus.bist_start = 1'b0;
    checkOutput("b2b_runs", 32'(rises), 32'(2));
    @(negedge clk);
    checkOutput("b2b_hold_done", 32'(bus.bist_done), 32'(1));
    checkOutput("b2b_hold_pass", 32'(bus.bist_pass), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
